mux3_rr_arbiter: RTL and testbench



---
 rtl/mux3_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_mux3_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter in front of a shared 3:1 data mux (d0/d1/d2 -> y).
// Grants the output path to one requester at a time in bursts of at most
// MAX_BURST accepted beats. The owner keeps the path until it drops its
// request or completes its last allowed beat. Handover to the next requester
// happens in the same edge, so no idle cycle is inserted between owners.
// The previous owner always has the lowest priority at re-arbitration.
module mux3_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic          ready,
    output logic [2:0]    gnt,
    output logic [1:0]    sel,
    output logic          valid,
    output logic          xfer,
    output logic [CW-1:0] beats
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Beat count value at which an accepted beat ends the burst.
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t        state_r;
    logic [2:0]    gnt_r;
    logic [1:0]    sel_r;
    logic [1:0]    last_r;
    logic [CW-1:0] beats_r;

    logic          any_req_s;
    logic          valid_s;
    logic          xfer_s;
    logic          last_beat_s;
    logic          release_s;
    logic [1:0]    prio_base_s;
    logic [1:0]    pick_s;

    // Search from base+1 upward (mod 3) and return the first requester found.
    // The result is meaningless for an empty mask; callers gate it with |mask.
    function automatic logic [1:0] arb_pick(input logic [2:0] mask, input logic [1:0] base);
        logic [1:0] idx;
        idx = 2'd0;
        case (base)
            2'd0: begin
                if (mask[1]) idx = 2'd1;
                else if (mask[2]) idx = 2'd2;
                else idx = 2'd0;
            end
            2'd1: begin
                if (mask[2]) idx = 2'd2;
                else if (mask[0]) idx = 2'd0;
                else idx = 2'd1;
            end
            default: begin
                if (mask[0]) idx = 2'd0;
                else if (mask[1]) idx = 2'd1;
                else idx = 2'd2;
            end
        endcase
        return idx;
    endfunction

    // Index to one-hot grant vector; an illegal index yields no grant.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Handshake decode, burst release condition and next-winner selection.
    always_comb begin
        any_req_s   = |req;
        valid_s     = |(gnt_r & req);
        xfer_s      = valid_s & ready;
        last_beat_s = (beats_r == LAST_BEAT);
        release_s   = 1'b0;
        prio_base_s = last_r;
        if (state_r == ST_GRANT) begin
            // The current owner becomes the new last pointer on release, so the
            // arbitration during a handover is based on it directly.
            release_s   = (!valid_s) || (xfer_s && last_beat_s);
            prio_base_s = sel_r;
        end else begin
            release_s   = 1'b0;
            prio_base_s = last_r;
        end
        pick_s = arb_pick(req, prio_base_s);
    end

    // Arbiter state machine with registered grant, select and beat count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            gnt_r   <= 3'b000;
            sel_r   <= 2'd0;
            last_r  <= 2'd2;
            beats_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r <= ST_GRANT;
                        gnt_r   <= onehot3(pick_s);
                        sel_r   <= pick_s;
                        beats_r <= '0;
                    end else begin
                        // sel keeps pointing at the last path used.
                        gnt_r <= 3'b000;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        last_r  <= sel_r;
                        beats_r <= '0;
                        if (any_req_s) begin
                            gnt_r <= onehot3(pick_s);
                            sel_r <= pick_s;
                        end else begin
                            state_r <= ST_IDLE;
                            gnt_r   <= 3'b000;
                        end
                    end else if (xfer_s) begin
                        beats_r <= beats_r + CW'(1);
                    end else begin
                        beats_r <= beats_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 3'b000;
                    beats_r <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign sel   = sel_r;
    assign beats = beats_r;
    assign valid = valid_s;
    assign xfer  = xfer_s;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: a cycle-level behavioural model
// (owner index, last owner, beat count) checked against the DUT every cycle,
// directed scenarios with hand-computed values, then randomized traffic.
module tb_mux3_rr_arbiter;

    localparam int MAX_BURST = 4;
    localparam int CW        = $clog2(MAX_BURST + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    req = 3'b000;
    logic          ready = 1'b0;
    logic [2:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic          xfer;
    logic [CW-1:0] beats;

    int checks = 0;
    int errors = 0;

    // Model state: owner -1 means idle.
    int m_owner = -1;
    int m_last  = 2;
    int m_beats = 0;
    int m_sel   = 0;
    bit m_on    = 1'b0;

    mux3_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .ready (ready),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .xfer  (xfer),
        .beats (beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Round-robin choice: first requester after 'last', wrapping mod 3.
    function automatic int arb(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    // Model advances one clock edge from the inputs sampled at that edge.
    always @(posedge clk) begin : model_update
        int  n_owner, n_last, n_beats, n_sel;
        bit  v, x;
        n_owner = m_owner;
        n_last  = m_last;
        n_beats = m_beats;
        n_sel   = m_sel;
        if (reset) begin
            n_owner = -1; n_last = 2; n_beats = 0; n_sel = 0;
        end else if (n_owner < 0) begin
            if (req != 3'b000) begin
                n_owner = arb(req, n_last);
                n_sel   = n_owner;
                n_beats = 0;
            end
        end else begin
            v = req[n_owner];
            x = v && ready;
            if (!v || (x && n_beats == MAX_BURST - 1)) begin
                n_last  = n_owner;
                n_beats = 0;
                if (req != 3'b000) begin
                    n_owner = arb(req, n_last);
                    n_sel   = n_owner;
                end else begin
                    n_owner = -1;
                end
            end else if (x) begin
                n_beats = n_beats + 1;
            end
        end
        if (reset) m_on <= 1'b1;
        m_owner <= n_owner;
        m_last  <= n_last;
        m_beats <= n_beats;
        m_sel   <= n_sel;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin : compare
        logic [2:0] e_gnt;
        logic       e_valid;
        if (m_on) begin
            e_gnt   = 3'b000;
            e_valid = 1'b0;
            if (m_owner >= 0) begin
                e_gnt   = 3'b001 << m_owner;
                e_valid = req[m_owner];
            end
            check("gnt",   32'(gnt),   32'(e_gnt));
            check("sel",   32'(sel),   32'(m_sel));
            check("beats", 32'(beats), 32'(m_beats));
            check("valid", 32'(valid), 32'(e_valid));
            check("xfer",  32'(xfer),  32'(e_valid && ready));
        end
    end

    // Apply inputs shortly after an edge; return just after the next negedge.
    task automatic drive(input logic [2:0] r, input logic rd, input logic rs);
        @(posedge clk);
        #2;
        req   = r;
        ready = rd;
        reset = rs;
        #4;
    endtask

    initial begin
        // Reset held with all requests active.
        drive(3'b111, 1'b1, 1'b1);
        drive(3'b111, 1'b1, 1'b1);
        check("rst_gnt",   32'(gnt),   32'h0);
        check("rst_sel",   32'(sel),   32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        drive(3'b111, 1'b1, 1'b0);
        drive(3'b111, 1'b1, 1'b0);
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_sel", 32'(sel), 32'h0);

        // All requesting, ready constant: 4-beat bursts rotating 0->1->2.
        for (int k = 0; k < 12; k++) begin
            if (k > 0) drive(3'b111, 1'b1, 1'b0);
            check("rr_gnt",   32'(gnt),   32'(3'b001 << (k / 4)));
            check("rr_sel",   32'(sel),   32'(k / 4));
            check("rr_beats", 32'(beats), 32'(k % 4));
            check("rr_xfer",  32'(xfer),  32'h1);
        end

        // Single requester 1: regranted after each burst with no gap.
        drive(3'b010, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            drive(3'b010, 1'b1, 1'b0);
            check("solo_gnt",   32'(gnt),   32'h2);
            check("solo_beats", 32'(beats), 32'(j % 4));
            check("solo_xfer",  32'(xfer),  32'h1);
        end

        // Owner 0 stalls on ready, then drops its request with req[2] pending.
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b001, 1'b1, 1'b0);
        check("idle_gnt", 32'(gnt), 32'h0);
        drive(3'b001, 1'b1, 1'b0);
        drive(3'b001, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            drive(3'b101, 1'b0, 1'b0);
            check("stall_valid", 32'(valid), 32'h1);
            check("stall_xfer",  32'(xfer),  32'h0);
            check("stall_beats", 32'(beats), 32'h2);
            check("stall_gnt",   32'(gnt),   32'h1);
        end
        drive(3'b100, 1'b1, 1'b0);
        check("drop_xfer", 32'(xfer), 32'h0);
        drive(3'b100, 1'b1, 1'b0);
        check("drop_gnt",   32'(gnt),   32'h4);
        check("drop_sel",   32'(sel),   32'h2);
        check("drop_beats", 32'(beats), 32'h0);

        // Reset mid-burst while a beat is being presented.
        drive(3'b100, 1'b1, 1'b0);
        drive(3'b100, 1'b1, 1'b1);
        check("midrst_beats", 32'(beats), 32'h2);
        check("midrst_xfer",  32'(xfer),  32'h1);
        drive(3'b110, 1'b1, 1'b0);
        check("postrst_gnt",   32'(gnt),   32'h0);
        check("postrst_beats", 32'(beats), 32'h0);
        drive(3'b110, 1'b1, 1'b0);
        check("postrst_win", 32'(gnt), 32'h2);
        check("postrst_sel", 32'(sel), 32'h1);

        // Burst by requester 2, then idle: sel holds at 2.
        drive(3'b100, 1'b1, 1'b0);
        drive(3'b100, 1'b1, 1'b0);
        check("r2_gnt", 32'(gnt), 32'h4);
        drive(3'b000, 1'b1, 1'b0);
        for (int j = 0; j < 2; j++) begin
            drive(3'b000, 1'b1, 1'b0);
            check("idle2_gnt",   32'(gnt),   32'h0);
            check("idle2_sel",   32'(sel),   32'h2);
            check("idle2_valid", 32'(valid), 32'h0);
        end
        drive(3'b101, 1'b1, 1'b0);
        drive(3'b101, 1'b1, 1'b0);
        check("wake_gnt", 32'(gnt), 32'h1);
        check("wake_sel", 32'(sel), 32'h0);

        // Randomized traffic with sticky requests and occasional resets.
        begin
            logic [2:0] r;
            r = 3'b000;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
                drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
            end
        end
        drive(3'b000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
